// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states, word layout, frame-length decode.
// Pure declarations; no latency or backpressure of its own.
// ST_CHK exists only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int WORD_W = ADDR_W + DATA_W;
  localparam int CNT_W  = 9;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CNT,
    ST_ADDR,
    ST_DATA,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
`ifdef LOADER_CHECKSUM_EN
    ST_CHK,
`endif
    ST_FIN
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_word_t;

  // A count byte of zero encodes a full 256-word frame.
  function automatic logic [CNT_W-1:0] frame_len(input logic [7:0] n);
    return (n == 8'd0) ? 9'd256 : {1'b0, n};
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Inbound byte stream from the host into the loader.
// Transfer occurs on a clock edge where s_valid && s_ready; the loader is the slave.
// No storage in the interface itself.
interface program_loader_if;
  import loader_pkg::*;

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/loader_strobe_gen.sv
// Write-port timing: holds the memory word, raises mem_done for one cycle, counts HOLD_CYC hold cycles.
// mem_done is registered and high exactly in the cycle after strobe_req is seen.
// No backpressure; driven entirely by the parent FSM.
module loader_strobe_gen
  import loader_pkg::*;
#(
  parameter int HOLD_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  mem_word_t         word_in,
  input  logic              strobe_req,
  input  logic              in_hold,
  output logic [WORD_W-1:0] mem_in,
  output logic              mem_done,
  output logic              hold_done
);

  localparam int HC_W = 4;

  mem_word_t       word_q, word_d;
  logic            mem_done_q, mem_done_d;
  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;

  assign hold_done = in_hold && (hold_cnt_q == HC_W'(HOLD_CYC - 1));

  // The word only changes on load, which the parent issues outside SETUP/STROBE/HOLD.
  always_comb begin
    word_d     = word_q;
    mem_done_d = strobe_req;
    hold_cnt_d = '0;
    if (load) begin
      word_d = word_in;
    end
    if (in_hold && !hold_done) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      mem_done_q <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      word_q     <= word_d;
      mem_done_q <= mem_done_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign mem_in   = word_q;
  assign mem_done = mem_done_q;

endmodule

// File: rtl/program_loader.sv
// Parses SYNC/count/addr/data byte frames and writes {addr,data} words to instruction memory; LOADER_CHECKSUM_EN adds an XOR checksum byte.
// Per word: 2 accepted bytes + SETUP + STROBE + HOLD_CYC cycles; load_ok pulses in FIN, the cycle after the last HOLD (or CHK).
// s_ready drops during SETUP/STROBE/HOLD/FIN and in reset; s_valid gaps simply stall the parser.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         HOLD_CYC  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  program_loader_if.slave     s,
  output logic [WORD_W-1:0]   mem_in,
  output logic                mem_done,
  output logic                mem_rw,
  output logic                busy,
  output logic                load_ok,
  output logic                load_err,
  output logic [CNT_W-1:0]    word_count
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   words_left_q, words_left_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               run_q, run_d;
  logic               rdy;
  logic               accept;
  logic               load_word;
  logic               hold_done;
  mem_word_t          word_in;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
  logic               err_q, err_d;
`endif

  assign accept  = s.s_valid && s.s_ready;
  assign word_in = '{addr: addr_q, data: s.s_data};

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    word_cnt_d   = word_cnt_q;
    addr_d       = addr_q;
    run_d        = 1'b1;
    load_word    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum_q;
    err_d        = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept && (s.s_data == SYNC_BYTE)) begin
          state_d    = ST_CNT;
          word_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = '0;
          err_d      = 1'b0;
`endif
        end
      end
      ST_CNT: begin
        if (accept) begin
          words_left_d = frame_len(s.s_data);
          state_d      = ST_ADDR;
`ifdef LOADER_CHECKSUM_EN
          csum_d       = csum_q ^ s.s_data;
`endif
        end
      end
      ST_ADDR: begin
        if (accept) begin
          addr_d  = s.s_data;
          state_d = ST_DATA;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ s.s_data;
`endif
        end
      end
      ST_DATA: begin
        if (accept) begin
          load_word = 1'b1;
          state_d   = ST_SETUP;
`ifdef LOADER_CHECKSUM_EN
          csum_d    = csum_q ^ s.s_data;
`endif
        end
      end
      ST_SETUP: state_d = ST_STROBE;
      ST_STROBE: begin
        if (word_cnt_q != 9'd256) begin
          word_cnt_d = word_cnt_q + 9'd1;
        end
        words_left_d = words_left_q - 9'd1;
        state_d      = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_done) begin
          if (words_left_q != '0) begin
            state_d = ST_ADDR;
          end else begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_FIN;
`endif
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept) begin
          if (s.s_data != csum_q) begin
            err_d = 1'b1;
          end
          state_d = ST_FIN;
        end
      end
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdy = 1'b0;
    case (state_q)
      ST_IDLE, ST_CNT, ST_ADDR, ST_DATA: rdy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: rdy = 1'b1;
`endif
      default: rdy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      words_left_q <= '0;
      word_cnt_q   <= '0;
      addr_q       <= '0;
      run_q        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      word_cnt_q   <= word_cnt_d;
      addr_q       <= addr_d;
      run_q        <= run_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
      err_q        <= err_d;
`endif
    end
  end

  loader_strobe_gen #(.HOLD_CYC(HOLD_CYC)) u_strobe (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_word),
    .word_in    (word_in),
    .strobe_req (state_d == ST_STROBE),
    .in_hold    (state_q == ST_HOLD),
    .mem_in     (mem_in),
    .mem_done   (mem_done),
    .hold_done  (hold_done)
  );

  // run_q keeps s_ready low for as long as reset is held.
  assign s.s_ready  = run_q && rdy;
  assign mem_rw     = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign word_count = word_cnt_q;
`ifdef LOADER_CHECKSUM_EN
  assign load_err   = err_q;
  assign load_ok    = (state_q == ST_FIN) && !err_q;
`else
  assign load_err   = 1'b0;
  assign load_ok    = (state_q == ST_FIN);
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with HOLD_CYC=3; a negedge monitor logs every strobe and checks mem_in stability.
module tb_program_loader;
  import loader_pkg::*;

  localparam int HOLD = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mem_in;
  logic        mem_done, mem_rw, busy, load_ok, load_err;
  logic [8:0]  word_count;

  program_loader_if bus();

  program_loader #(.SYNC_BYTE(8'hA5), .HOLD_CYC(HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (bus.slave),
    .mem_in     (mem_in),
    .mem_done   (mem_done),
    .mem_rw     (mem_rw),
    .busy       (busy),
    .load_ok    (load_ok),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] frame_q[$];
  logic [15:0] wr_q[$];
  bit          gap_en = 1'b0;
  int          cyc = 0;
  int          ok_pulses = 0;
  int          stab_err = 0;
  int          win = 0;
  int          last_strobe_cyc = 0;
  int          strobe_gap = 0;
  logic        prev_done = 1'b0;
  logic [15:0] prev_mem = 16'h0;
  logic [15:0] win_val = 16'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory-side monitor: a write is the rising edge of mem_done.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      win = 0;
    end else begin
      if (mem_done && !prev_done) begin
        wr_q.push_back(mem_in);
        if (mem_in !== prev_mem) stab_err++;
        win_val         = mem_in;
        win             = HOLD;
        strobe_gap      = cyc - last_strobe_cyc;
        last_strobe_cyc = cyc;
      end else if (win > 0) begin
        if (mem_in !== win_val) stab_err++;
        win--;
      end
      if (mem_done && prev_done) stab_err++;
      if (load_ok) ok_pulses++;
    end
    prev_done = mem_done;
    prev_mem  = mem_in;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gap_en) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    n = 0;
    while (!bus.s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) check("rdy_timeout", {31'd0, bus.s_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] n);
    logic [7:0] cs;
    cs = n;
    send_byte(8'hA5);
    send_byte(n);
    foreach (frame_q[i]) begin
      send_byte(frame_q[i][15:8]);
      send_byte(frame_q[i][7:0]);
      cs = cs ^ frame_q[i][15:8] ^ frame_q[i][7:0];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs);
`endif
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int w0, ok0, bad, n;
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;

    #2;
    check("rst_mem_in", {16'd0, mem_in}, 32'h0);
    check("rst_mem_done", {31'd0, mem_done}, 32'd0);
    check("rst_mem_rw", {31'd0, mem_rw}, 32'd1);
    check("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_load_ok", {31'd0, load_ok}, 32'd0);
    check("rst_load_err", {31'd0, load_err}, 32'd0);
    check("rst_word_count", {23'd0, word_count}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_s_ready", {31'd0, bus.s_ready}, 32'd1);

    // Two-word frame, back-to-back bytes.
    w0 = wr_q.size(); ok0 = ok_pulses;
    frame_q = '{16'h103C, 16'h117E};
    send_frame(8'h02);
    wait_idle();
    check("a_writes", wr_q.size() - w0, 32'd2);
    check("a_word0", {16'd0, wr_q[w0]}, 32'h103C);
    check("a_word1", {16'd0, wr_q[w0+1]}, 32'h117E);
    check("a_word_count", {23'd0, word_count}, 32'd2);
    check("a_load_ok", ok_pulses - ok0, 32'd1);
    check("a_strobe_gap", strobe_gap, 32'd7);
    check("a_mem_rw", {31'd0, mem_rw}, 32'd1);

    // Noise ahead of the sync byte is dropped.
    w0 = wr_q.size(); ok0 = ok_pulses;
    send_byte(8'h00);
    send_byte(8'hFF);
    frame_q = '{16'h2055};
    send_frame(8'h01);
    wait_idle();
    check("noise_writes", wr_q.size() - w0, 32'd1);
    check("noise_word", {16'd0, wr_q[w0]}, 32'h2055);
    check("noise_word_count", {23'd0, word_count}, 32'd1);
    check("noise_load_ok", ok_pulses - ok0, 32'd1);

    // Sync byte inside a frame is plain data.
    w0 = wr_q.size();
    frame_q = '{16'hA5A5};
    send_frame(8'h01);
    wait_idle();
    check("sync_data_word", {16'd0, wr_q[w0]}, 32'hA5A5);

    // Count byte 00 means 256 words.
    w0 = wr_q.size(); ok0 = ok_pulses;
    frame_q.delete();
    for (int i = 0; i < 256; i++) begin
      frame_q.push_back({i[7:0], ~i[7:0]});
    end
    send_frame(8'h00);
    wait_idle();
    check("full_writes", wr_q.size() - w0, 32'd256);
    check("full_word_count", {23'd0, word_count}, 32'd256);
    check("full_load_ok", ok_pulses - ok0, 32'd1);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (wr_q[w0+i] !== {i[7:0], ~i[7:0]}) bad++;
    end
    check("full_contents", bad, 32'd0);

    // Random valid gaps; mem_in must hold SETUP..HOLD for each word.
    gap_en = 1'b1;
    w0 = wr_q.size();
    frame_q = '{16'h0011, 16'h01EE, 16'h02C3, 16'h033C};
    send_frame(8'h04);
    wait_idle();
    gap_en = 1'b0;
    check("gap_writes", wr_q.size() - w0, 32'd4);
    check("gap_word3", {16'd0, wr_q[w0+3]}, 32'h033C);
    check("gap_word_count", {23'd0, word_count}, 32'd4);
    check("mem_in_stable", stab_err, 32'd0);

    // Reset in STROBE aborts immediately.
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h30);
    send_byte(8'h31);
    n = 0;
    @(negedge clk);
    while (!mem_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_strobe_seen", {31'd0, mem_done}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_done", {31'd0, mem_done}, 32'd0);
    check("rst_mid_mem_rw", {31'd0, mem_rw}, 32'd1);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_s_ready", {31'd0, bus.s_ready}, 32'd0);
    check("rst_mid_word_count", {23'd0, word_count}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_q.size(); ok0 = ok_pulses;
    frame_q = '{16'h4242};
    send_frame(8'h01);
    wait_idle();
    check("post_rst_writes", wr_q.size() - w0, 32'd1);
    check("post_rst_word", {16'd0, wr_q[w0]}, 32'h4242);
    check("post_rst_load_ok", ok_pulses - ok0, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    ok0 = ok_pulses;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05); send_byte(8'h07); send_byte(8'h03);
    wait_idle();
    check("csum_good_ok", ok_pulses - ok0, 32'd1);
    check("csum_good_err", {31'd0, load_err}, 32'd0);
    ok0 = ok_pulses;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05); send_byte(8'h07); send_byte(8'h04);
    wait_idle();
    check("csum_bad_ok", ok_pulses - ok0, 32'd0);
    check("csum_bad_err", {31'd0, load_err}, 32'd1);
    send_byte(8'hA5);
    @(negedge clk);
    check("csum_err_cleared", {31'd0, load_err}, 32'd0);
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h07); send_byte(8'h03);
    wait_idle();
`else
    check("no_csum_err", {31'd0, load_err}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
